// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
//   Bundle between the 5-stage pipeline and its hazard controller.
//
//   Pipeline -> controller:
//     IF_ID_rs, IF_ID_rt  source registers of the instruction in ID
//     ID_uses_rt          ID instruction reads rt
//     ID_uses_hilo        ID instruction is MFHI/MFLO/MULT/DIV
//     ID_EX_rt            destination of the instruction in EX
//     ID_EX_memRead       instruction in EX is a load
//     branch_taken        EX resolved a taken branch/jump
//     md_start, md_is_div MULT/DIV launch pulse and its divide qualifier
//   Controller -> pipeline:
//     pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble
//     md_busy, md_done (HI/LO write strobe), md_overrun (sticky error)
//     perf_stall_cycles, perf_flush_count (only with HAZARD_PERF_EN)
//
//   Modports: master = pipeline side, slave = hazard controller.
// ---------------------------------------------------------------------------
interface hazard_controller_if;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        ID_uses_rt;
  logic        ID_uses_hilo;
  logic [4:0]  ID_EX_rt;
  logic        ID_EX_memRead;
  logic        branch_taken;
  logic        md_start;
  logic        md_is_div;

  logic        pc_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        md_busy;
  logic        md_done;
  logic        md_overrun;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_uses_hilo, ID_EX_rt,
           ID_EX_memRead, branch_taken, md_start, md_is_div,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
           md_busy, md_done, md_overrun
`ifdef HAZARD_PERF_EN
    , input perf_stall_cycles, perf_flush_count
`endif
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_uses_rt, ID_uses_hilo, ID_EX_rt,
           ID_EX_memRead, branch_taken, md_start, md_is_div,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
           md_busy, md_done, md_overrun
`ifdef HAZARD_PERF_EN
    , output perf_stall_cycles, perf_flush_count
`endif
  );
endinterface

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing for the 5-stage MIPS core: load-use stalls, EX-resolved
//   branch/jump flushes, and sequencing of the multi-cycle MULT/DIV unit via
//   an internal busy counter.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     hz     hazard_controller_if.slave (see interface for signal list)
//
//   Parameters:
//     MULT_CYCLES  busy cycles for MULT/MULTU (1 .. 2**CNT_W-1)
//     DIV_CYCLES   busy cycles for DIV/DIVU   (1 .. 2**CNT_W-1)
//     CNT_W        width of the multi-cycle counter
//
//   Optional build macro HAZARD_PERF_EN adds the 32-bit performance counters
//   perf_stall_cycles and perf_flush_count on the interface.
// ---------------------------------------------------------------------------
module hazard_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_controller_if.slave   hz
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  logic [CNT_W-1:0] md_cnt_q;
  logic [CNT_W-1:0] md_cnt_d;
  logic             md_done_q;
  logic             md_overrun_q;

  logic             md_busy;
  logic             load_haz;
  logic             md_haz;
  logic             stall_req;

  // Hazard detection
  // $0 is hard-wired zero, so a load "to" $0 never produces a dependency.
  assign load_haz = hz.ID_EX_memRead && (hz.ID_EX_rt != 5'd0) &&
                    ((hz.ID_EX_rt == hz.IF_ID_rs) ||
                     (hz.ID_uses_rt && (hz.ID_EX_rt == hz.IF_ID_rt)));

  assign md_busy   = (md_cnt_q != CNT_ZERO);
  assign md_haz    = md_busy && hz.ID_uses_hilo;
  assign stall_req = load_haz || md_haz;

  // Multi-cycle counter next state. A start that arrives while the unit is
  // occupied is dropped; it only raises the overrun flag.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.md_start && !md_busy) begin
      md_cnt_d = hz.md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - CNT_ONE;
    end
  end

  // State registers
  // md_done fires in the first idle cycle after the count expires, which is
  // also the cycle the stalled MFHI/MFLO is released from ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q     <= CNT_ZERO;
      md_done_q    <= 1'b0;
      md_overrun_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_done_q <= (md_cnt_q == CNT_ONE);
      if (hz.md_start && md_busy) begin
        md_overrun_q <= 1'b1;
      end
    end
  end

  // Pipeline control. A taken branch wins over any stall: the instruction
  // in ID is being squashed anyway, so holding it would be pointless. The
  // counter keeps running because the MULT/DIV is older than the branch.
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EX_bubble = 1'b0;
    if (hz.branch_taken) begin
      hz.IF_ID_flush  = 1'b1;
      hz.ID_EX_bubble = 1'b1;
    end else if (stall_req) begin
      hz.pc_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EX_bubble = 1'b1;
    end
  end

  assign hz.md_busy    = md_busy;
  assign hz.md_done    = md_done_q;
  assign hz.md_overrun = md_overrun_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Performance counters; both wrap naturally at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_req && !hz.branch_taken) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (hz.branch_taken) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cycles = perf_stall_q;
  assign hz.perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Directed-vector bench for hazard_controller. Each stimulus cycle pushes a
//   hand-computed expected output vector into a scoreboard queue; a monitor
//   pops one entry per cycle on the falling edge and compares.
//   Expected vector bit order:
//     {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, md_busy, md_done,
//      md_overrun}
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if bus ();

  hazard_controller #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (16),
    .CNT_W       (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       hl;
    logic [4:0] exrt;
    logic       mr;
    logic       br;
    logic       st;
    logic       dv;
    logic       rstn;
  } in_t;

  // Upper four expected bits: pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble
  localparam logic [3:0] N = 4'b1100;  // normal flow
  localparam logic [3:0] S = 4'b0001;  // stall
  localparam logic [3:0] F = 4'b1111;  // flush

  int checks   = 0;
  int failures = 0;

  string      tag_q[$];
  logic [6:0] exp_q[$];

  in_t idle_v;
  in_t v;

  task automatic step(input string tag, input in_t iv, input logic [6:0] e);
    @(posedge clk);
    #1;
    rst_n              = iv.rstn;
    bus.IF_ID_rs       = iv.rs;
    bus.IF_ID_rt       = iv.rt;
    bus.ID_uses_rt     = iv.ur;
    bus.ID_uses_hilo   = iv.hl;
    bus.ID_EX_rt       = iv.exrt;
    bus.ID_EX_memRead  = iv.mr;
    bus.branch_taken   = iv.br;
    bus.md_start       = iv.st;
    bus.md_is_div      = iv.dv;
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    string      t;
    logic [6:0] e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        act = {bus.pc_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_bubble,
               bus.md_busy, bus.md_done, bus.md_overrun};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %b expected %b", t, act, e);
        end
      end
    end
  end

  initial begin
    idle_v = '{rs: 5'd0, rt: 5'd0, ur: 1'b0, hl: 1'b0, exrt: 5'd0, mr: 1'b0,
               br: 1'b0, st: 1'b0, dv: 1'b0, rstn: 1'b1};
    bus.IF_ID_rs = '0; bus.IF_ID_rt = '0; bus.ID_uses_rt = 1'b0;
    bus.ID_uses_hilo = 1'b0; bus.ID_EX_rt = '0; bus.ID_EX_memRead = 1'b0;
    bus.branch_taken = 1'b0; bus.md_start = 1'b0; bus.md_is_div = 1'b0;

    // Reset state (a start pulse during reset must not load the counter)
    v = idle_v; v.rstn = 1'b0; v.st = 1'b1;
    step("reset", v, {N, 3'b000});
    v = idle_v;
    step("post_reset", v, {N, 3'b000});

    // Load-use hazards
    v = idle_v; v.mr = 1; v.exrt = 5'd8; v.rs = 5'd8;
    step("load_rs", v, {S, 3'b000});
    v.mr = 0;
    step("load_released", v, {N, 3'b000});
    v = idle_v; v.mr = 1; v.exrt = 5'd9; v.rt = 5'd9; v.ur = 1;
    step("load_rt_used", v, {S, 3'b000});
    v = idle_v; v.mr = 1; v.exrt = 5'd0; v.rs = 5'd0;
    step("load_zero_reg", v, {N, 3'b000});
    v = idle_v; v.mr = 1; v.exrt = 5'd9; v.rt = 5'd9; v.ur = 0;
    step("load_rt_unused", v, {N, 3'b000});
    v = idle_v; v.mr = 1; v.exrt = 5'd8; v.rs = 5'd8; v.br = 1;
    step("flush_beats_load", v, {F, 3'b000});

    // MULT: 4 busy cycles, done in the 5th
    v = idle_v; v.st = 1; v.hl = 1;
    step("mult_start", v, {N, 3'b000});
    v = idle_v; v.hl = 1;
    for (int i = 0; i < 4; i++) step("mult_busy", v, {S, 3'b100});
    step("mult_done", v, {N, 3'b010});
    step("mult_after", v, {N, 3'b000});

    // DIV: 16 busy cycles, done in the 17th
    v = idle_v; v.st = 1; v.dv = 1;
    step("div_start", v, {N, 3'b000});
    v = idle_v; v.hl = 1;
    for (int i = 0; i < 16; i++) step("div_busy", v, {S, 3'b100});
    step("div_done", v, {N, 3'b010});

    // Start and branch in the same cycle; flush during busy keeps counting
    v = idle_v; v.st = 1; v.br = 1;
    step("start_and_branch", v, {F, 3'b000});
    v = idle_v; v.hl = 1; v.br = 1;
    step("flush_while_busy", v, {F, 3'b100});
    v.br = 0;
    for (int i = 0; i < 3; i++) step("busy_after_flush", v, {S, 3'b100});
    step("done_after_flush", v, {N, 3'b010});

    // Overrun: second start ignored (a DIV reload would extend busy)
    v = idle_v; v.st = 1;
    step("ovr_first_start", v, {N, 3'b000});
    v.dv = 1;
    step("ovr_second_start", v, {N, 3'b100});
    v = idle_v;
    for (int i = 0; i < 3; i++) step("ovr_sticky_busy", v, {N, 3'b101});
    step("ovr_done", v, {N, 3'b011});
    step("ovr_sticky_idle", v, {N, 3'b001});

    // Reset mid-count at counter=3: busy/overrun clear, no md_done follows
    v = idle_v; v.st = 1;
    step("rst_start", v, {N, 3'b001});
    v = idle_v;
    step("rst_cnt4", v, {N, 3'b101});
    v.rstn = 0;
    step("rst_at_cnt3", v, {N, 3'b000});
    v.rstn = 1;
    for (int i = 0; i < 5; i++) step("rst_no_done", v, {N, 3'b000});

`ifdef HAZARD_PERF_EN
    v = idle_v; v.rstn = 0;
    step("perf_reset", v, {N, 3'b000});
    v = idle_v; v.mr = 1; v.exrt = 5'd8; v.rs = 5'd8;
    for (int i = 0; i < 3; i++) step("perf_stall", v, {S, 3'b000});
    v = idle_v; v.br = 1;
    for (int i = 0; i < 2; i++) step("perf_flush", v, {F, 3'b000});
    v = idle_v;
    step("perf_idle", v, {N, 3'b000});
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL perf_stall_cycles: got %0d expected 3", bus.perf_stall_cycles);
    end
    checks++;
    if (bus.perf_flush_count !== 32'd2) begin
      failures++;
      $display("FAIL perf_flush_count: got %0d expected 2", bus.perf_flush_count);
    end
    force dut.perf_stall_q = 32'hFFFF_FFFF;
    v = idle_v; v.mr = 1; v.exrt = 5'd8; v.rs = 5'd8;
    step("perf_wrap_stall", v, {S, 3'b000});
    release dut.perf_stall_q;
    v = idle_v;
    step("perf_wrap_idle", v, {N, 3'b000});
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL perf_wrap: got %h expected 00000000", bus.perf_stall_cycles);
    end
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It produces PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush for three cases:
- load-use hazards that the forwarding path cannot cover;
- taken branches and jumps resolved in EX;
- a multi-cycle MULT/DIV unit, which it sequences with an internal busy counter.

It sits beside the forwarding unit and drives the pipeline registers and the HI/LO write strobe.

Parameters:
MULT_CYCLES, 4, busy cycles for MULT/MULTU (1..2^CNT_W-1)
DIV_CYCLES, 16, busy cycles for DIV/DIVU (1..2^CNT_W-1)
CNT_W, 5, width of the multi-cycle counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
IF_ID_rs  in  5  rs of the instruction in ID
IF_ID_rt  in  5  rt of the instruction in ID
ID_uses_rt  in  1  ID instruction reads rt as a source
ID_uses_hilo  in  1  ID instruction is MFHI/MFLO/MULT/DIV
ID_EX_rt  in  5  destination of the instruction in EX
ID_EX_memRead  in  1  instruction in EX is a load
branch_taken  in  1  EX resolved a taken branch or jump
md_start  in  1  MULT/DIV in EX (one-cycle pulse)
md_is_div  in  1  qualifies md_start: 1 = divide
pc_write  out  1  PC load enable
IF_ID_write  out  1  IF/ID load enable
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EX_bubble  out  1  zero the ID/EX control fields
md_busy  out  1  multi-cycle unit occupied
md_done  out  1  one-cycle HI/LO write strobe
md_overrun  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - md counter=0, md_done=0, md_overrun=0.
  - Combinational outputs settle to pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, md_busy=0.
- Load-use hazard, combinational:
  - load_haz = ID_EX_memRead && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || (ID_uses_rt && ID_EX_rt==IF_ID_rt)).
- Multi-cycle hazard:
  - md_haz = md_busy && ID_uses_hilo.
  - md_busy = (counter!=0), combinational.
- Counter:
  - md_start && counter==0: load md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - Else if counter!=0: decrement.
  - md_start while counter!=0: ignored (counter unaffected); md_overrun set and held until reset.
- md_done, registered:
  - md_done <= (counter==1), so it is high exactly one cycle, in the first cycle counter==0.
  - Example, MULT_CYCLES=4, start accepted at edge E0: md_busy high for 4 cycles, md_done high in the 5th.
- Priority 1, flush (branch_taken=1):
  - IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1.
  - Overrides all stalls for that cycle.
- Priority 2, stall (md_haz or load_haz, no flush):
  - pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
- Otherwise: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
- Load stall is one cycle by construction: the bubble clears ID_EX_memRead the next cycle.
- md stall lasts until md_busy drops. ID proceeds in the md_done cycle, so HI/LO is written at the end of that cycle.
- A flush during md_busy does not abort the counter (the MULT/DIV is older than the branch).
- md_start and branch_taken in the same cycle: both honoured.
- rst_n asserted mid-count: counter returns to 0 immediately; no md_done is emitted.
- Register $0 never causes a load stall.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cycles (32 bits) and perf_flush_count (32 bits), both reset to 0 asynchronously.
  - perf_stall_cycles increments each cycle the stall condition is active.
  - perf_flush_count increments each cycle branch_taken=1.
  - Both wrap 0xFFFFFFFF -> 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use on rs: ID_EX_memRead=1, ID_EX_rt=8, IF_ID_rs=8 -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly one cycle; next cycle (memRead=0) all normal.
- $0 and unused-rt cases:
  - ID_EX_rt=0=IF_ID_rs with memRead=1 -> no stall.
  - IF_ID_rt match with ID_uses_rt=0 -> no stall.
- MULT sequencing: md_start=1, md_is_div=0, then ID_uses_hilo=1 -> md_busy and stall for 4 cycles, md_done=1 in cycle 5 with stall released; DIV gives 16 busy cycles and md_done in cycle 17.
- Flush beats stall: branch_taken=1 together with load_haz=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1.
- Overrun and reset:
  - md_start during busy -> counter unchanged, md_overrun=1 and sticky.
  - rst_n=0 at counter=3 -> md_busy=0, md_overrun=0, and no md_done follows.
- HAZARD_PERF_EN:
  - 3 stall cycles + 2 flushes -> perf_stall_cycles=3, perf_flush_count=2.
  - perf_stall_cycles preset to 0xFFFFFFFF plus one stall -> 0.
